// File: rtl/keypad_pkg.sv
// Shared types, defaults and row-decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  localparam int SCAN_DIV_DEF = 4096;
  localparam int DEBOUNCE_CYC_DEF = 500000;
  localparam logic [3:0] ROW_IDLE = 4'b1111;

  function automatic logic [1:0] low_idx(
    input logic [3:0] r
  );
    low_idx = 2'd0;
    if (!r[0]) low_idx = 2'd0;
    else if (!r[1]) low_idx = 2'd1;
    else if (!r[2]) low_idx = 2'd2;
    else if (!r[3]) low_idx = 2'd3;
  endfunction

  // Latched row still low and no lower-index row has taken over.
  function automatic logic row_stable(
    input logic [3:0] r,
    input logic [1:0] idx
  );
    logic [3:0] bit_m;
    logic [3:0] low_m;
    logic [3:0] span;
    bit_m = 4'b0001 << idx;
    low_m = bit_m - 4'd1;
    span = bit_m | low_m;
    row_stable = ((r & span) == low_m);
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Parameterised-width two-flop synchronizer, resets to all-ones (idle rows).
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         clk_50M,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      s1 <= '1;
      q <= '1;
    end else begin
      s1 <= d;
      q <= s1;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounced press/release and key history.
// Optional KEYPAD_SCAN_ENTRY_SHIFT_EN keeps the last four codes in entry_data.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down,
  output logic [15:0] entry_data
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_MAX = BW'(DEBOUNCE_CYC - 1);

  state_t state;
  state_t state_nx;

  logic [3:0] rs;
  logic [1:0] ci;
  logic [1:0] row_idx;
  logic [DW-1:0] div;
  logic [BW-1:0] deb;

  logic div_end;
  logic rs_idle;
  logic row_ok;
  logic accept;
  logic done;

  keypad_sync #(
    .W(4)
  ) u_sync (
    .clk_50M(clk_50M),
    .reset(reset),
    .d(row),
    .q(rs)
  );

  assign div_end = (div == DIV_MAX);
  assign rs_idle = (rs == ROW_IDLE);
  assign row_ok = row_stable(rs, row_idx);
  assign done = (deb == DEB_MAX);

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) state <= SCAN;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      SCAN: begin
        if (div_end && !rs_idle) state_nx = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (!row_ok) state_nx = SCAN;
        else if (done) state_nx = HELD;
      end
      HELD: begin
        if (rs_idle) state_nx = RELEASE;
      end
      RELEASE: begin
        if (!rs_idle) state_nx = HELD;
        else if (done) state_nx = SCAN;
      end
      default: state_nx = SCAN;
    endcase
  end

  always_comb begin
    col = ~(4'b0001 << ci);
    accept = (state == DEBOUNCE) && row_ok && done;
  end

  // Divider, column index and debounce counter.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      ci <= 2'd0;
      row_idx <= 2'd0;
      div <= '0;
      deb <= '0;
    end else begin
      unique case (state)
        SCAN: begin
          if (div_end) begin
            div <= '0;
            if (rs_idle) begin
              ci <= ci + 2'd1;
            end else begin
              row_idx <= low_idx(rs);
              deb <= '0;
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        DEBOUNCE: begin
          if (!row_ok) div <= '0;
          else if (!done) deb <= deb + BW'(1);
        end
        HELD: begin
          if (rs_idle) deb <= '0;
        end
        RELEASE: begin
          if (rs_idle) begin
            if (done) begin
              ci <= ci + 2'd1;
              div <= '0;
            end else begin
              deb <= deb + BW'(1);
            end
          end
        end
        default: begin
          div <= '0;
          deb <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      key_code <= 4'h0;
      key_valid <= 1'b0;
      key_down <= 1'b0;
    end else begin
      key_valid <= accept;
      key_down <= (state_nx == HELD) || (state_nx == RELEASE);
      if (accept) key_code <= {row_idx, ci};
    end
  end

`ifdef KEYPAD_SCAN_ENTRY_SHIFT_EN
  logic [15:0] entry_q;

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) entry_q <= 16'h0000;
    else if (accept) entry_q <= {entry_q[11:0], row_idx, ci};
  end

  assign entry_data = entry_q;
`else
  assign entry_data = 16'h0000;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Randomised keypad-matrix bench for keypad_scan against a behavioural model.
// Build with KEYPAD_SCAN_ENTRY_SHIFT_EN to also check the entry history.
module tb_keypad_scan;

  localparam int SD = 8;
  localparam int DC = 16;

  logic clk_50M = 1'b0;
  logic reset = 1'b0;
  logic [3:0] row = 4'hF;
  logic [3:0] col;
  logic [3:0] key_code;
  logic key_valid;
  logic key_down;
  logic [15:0] entry_data;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] pressed = 16'h0;
  logic bounce = 1'b0;

  keypad_scan #(
    .SCAN_DIV(SD),
    .DEBOUNCE_CYC(DC)
  ) dut (
    .clk_50M(clk_50M),
    .reset(reset),
    .row(row),
    .col(col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_down(key_down),
    .entry_data(entry_data)
  );

  always #10 clk_50M = ~clk_50M;

  // Reference model: phases 0 scan, 1 confirm press, 2 held, 3 confirm release.
  logic [3:0] q1, q2;
  int m_phase, m_ci, m_tick, m_run, m_row;
  logic [3:0] m_code;
  logic m_valid, m_down;
  logic [15:0] m_entry;

  always @(posedge clk_50M or posedge reset) begin
    logic [3:0] rs;
    logic ok;
    if (reset) begin
      q1 = 4'hF; q2 = 4'hF;
      m_phase = 0; m_ci = 0; m_tick = 0; m_run = 0; m_row = 0;
      m_code = 4'h0; m_valid = 1'b0; m_down = 1'b0; m_entry = 16'h0;
    end else begin
      rs = q2;
      q2 = q1;
      q1 = row;
      m_valid = 1'b0;
      case (m_phase)
        0: begin
          if (m_tick == SD - 1) begin
            m_tick = 0;
            if (rs == 4'hF) begin
              m_ci = (m_ci + 1) % 4;
            end else begin
              m_row = 3;
              for (int j = 3; j >= 0; j--) if (!rs[j]) m_row = j;
              m_run = 0;
              m_phase = 1;
            end
          end else begin
            m_tick++;
          end
        end
        1: begin
          ok = !rs[m_row];
          for (int j = 0; j < m_row; j++) if (!rs[j]) ok = 1'b0;
          if (!ok) begin
            m_phase = 0;
            m_tick = 0;
          end else begin
            m_run++;
            if (m_run == DC) begin
              m_phase = 2;
              m_code = 4'(m_row * 4 + m_ci);
              m_valid = 1'b1;
`ifdef KEYPAD_SCAN_ENTRY_SHIFT_EN
              m_entry = {m_entry[11:0], m_code};
`endif
            end
          end
        end
        2: begin
          if (rs == 4'hF) begin
            m_run = 0;
            m_phase = 3;
          end
        end
        default: begin
          if (rs != 4'hF) begin
            m_phase = 2;
          end else begin
            m_run++;
            if (m_run == DC) begin
              m_phase = 0;
              m_ci = (m_ci + 1) % 4;
              m_tick = 0;
            end
          end
        end
      endcase
      m_down = (m_phase >= 2);
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Key matrix: pressed key (r,c) pulls row r low while column c is driven.
  task automatic drive_row();
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 4; i++) if (pressed[i * 4 + m_ci]) r[i] = 1'b0;
    if (bounce && $urandom_range(0, 2) == 0) r = 4'hF;
    row = r;
  endtask

  task automatic cycle();
    logic [3:0] ecol;
    @(posedge clk_50M);
    @(negedge clk_50M);
    ecol = ~(4'b0001 << m_ci);
    check("col", 16'(col), 16'(ecol));
    check("key_valid", 16'(key_valid), 16'(m_valid));
    check("key_down", 16'(key_down), 16'(m_down));
    check("key_code", 16'(key_code), 16'(m_code));
    check("entry_data", entry_data, m_entry);
    drive_row();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_col", 16'(col), 16'hE);
    check("rst_valid", 16'(key_valid), 16'h0);
    check("rst_down", 16'(key_down), 16'h0);
    check("rst_code", 16'(key_code), 16'h0);
    check("rst_entry", entry_data, 16'h0);
    cycle();
    reset = 1'b0;
    drive_row();
  endtask

  task automatic wait_valid(input string tag, output int waited);
    waited = 0;
    while (!key_valid && waited < 300) begin
      cycle();
      waited++;
    end
    check(tag, 16'(key_valid), 16'h1);
  endtask

  task automatic wait_up(input string tag);
    int n;
    n = 0;
    while (key_down && n < 300) begin
      cycle();
      n++;
    end
    check(tag, 16'(key_down), 16'h0);
  endtask

  task automatic press_key(input logic [3:0] code);
    int w;
    bounce = 1'b0;
    pressed = 16'h1 << code;
    wait_valid("press_timeout", w);
    check("press_code", 16'(key_code), 16'(code));
    run(4);
    pressed = 16'h0;
    wait_up("release_timeout");
    run(3);
  endtask

  initial begin
    int w;
    int pulses;
    logic [15:0] ent;
    #1;
    reset = 1'b1;
    @(negedge clk_50M);
    check("init_col", 16'(col), 16'hE);
    check("init_down", 16'(key_down), 16'h0);
    reset = 1'b0;
    drive_row();

    // Idle scan: model tracks the column rotation.
    run(40);

    // Key 9 (row 2, column 1).
    pressed = 16'h1 << 9;
    wait_valid("k9_timeout", w);
    check("k9_code", 16'(key_code), 16'h9);
    check("k9_col", 16'(col), 16'hD);
    check("k9_down", 16'(key_down), 16'h1);
    run(5);

    // Release glitch then clean release.
    pressed = 16'h0;
    run(6);
    pressed = 16'h1 << 9;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (key_valid) pulses++;
    end
    check("glitch_pulses", 16'(pulses), 16'h0);
    check("glitch_down", 16'(key_down), 16'h1);
    pressed = 16'h0;
    wait_up("k9_release");
    check("k9_next_col", 16'(col), 16'hB);
    run(20);

    // Bouncing press of key 9 must not be accepted.
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      pressed = 16'h1 << 9;
      for (int i = 0; i < 5; i++) begin
        cycle();
        if (key_valid) pulses++;
      end
      pressed = 16'h0;
      for (int i = 0; i < 3; i++) begin
        cycle();
        if (key_valid) pulses++;
      end
    end
    check("bounce_pulses", 16'(pulses), 16'h0);

    // Two keys in one column: the lower row wins.
    pressed = (16'h1 << 14) | (16'h1 << 6);
    wait_valid("multi_timeout", w);
    check("multi_code", 16'(key_code), 16'h6);
    run(3);
    pressed = 16'h0;
    wait_up("multi_release");

    // Entry history.
    press_key(4'h1);
    press_key(4'h2);
    press_key(4'h3);
    press_key(4'h4);
    ent = 16'h0;
`ifdef KEYPAD_SCAN_ENTRY_SHIFT_EN
    ent = 16'h1234;
`endif
    check("entry_1234", entry_data, ent);
    press_key(4'hA);
`ifdef KEYPAD_SCAN_ENTRY_SHIFT_EN
    ent = 16'h234A;
`endif
    check("entry_234A", entry_data, ent);
    check("hold_code", 16'(key_code), 16'hA);

    // Reset while held forces a full new debounce.
    pressed = 16'h1 << 5;
    wait_valid("rst_press_timeout", w);
    run(3);
    do_reset();
    wait_valid("rst_redebounce_timeout", w);
    check("rst_redebounce_len", 16'(w >= DC), 16'h1);
    check("rst_code_again", 16'(key_code), 16'h5);
    pressed = 16'h0;
    wait_up("rst_release");

    // Randomised presses, bounces, multi-key and resets.
    for (int it = 0; it < 45; it++) begin
      pressed = 16'h1 << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) pressed |= 16'h1 << $urandom_range(0, 15);
      bounce = ($urandom_range(0, 3) == 0);
      run($urandom_range(5, 90));
      if ($urandom_range(0, 9) == 0) do_reset();
      pressed = 16'h0;
      bounce = ($urandom_range(0, 3) == 0);
      run($urandom_range(3, 40));
      bounce = 1'b0;
      run($urandom_range(0, 30));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, 4096, clk_50M cycles each column is driven before advancing; legal range 4..65535.
REQ-002 Parameter DEBOUNCE_CYC, 500000, cycles a row state must hold stable (10 ms at 50 MHz); legal range 2..2^20-1.
REQ-003 clk_50M  input  1  system clock, 50 MHz.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 row  input  4  keypad row lines, active-low, asynchronous to clk_50M, externally pulled high.
REQ-006 col  output  4  column drive, active-low one-hot.
REQ-007 key_code  output  4  hex code of the last accepted key, {row_idx[1:0], col_idx[1:0]}.
REQ-008 key_valid  output  1  one-cycle pulse per accepted key press.
REQ-009 key_down  output  1  level; high while an accepted key is held or its release is being debounced.
REQ-010 entry_data  output  16  last four accepted codes, newest in [3:0]; feeds the 4-digit display data word.

Function
REQ-011 row SHALL pass a 2-flop synchronizer before use; all decisions SHALL use the synchronized value rs.
REQ-012 Column index ci (2 bits) SHALL drive col = ~(4'b0001 << ci).
REQ-013 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-014 SCAN: a divider counts 0..SCAN_DIV-1; rs is sampled only when the count reaches SCAN_DIV-1; if rs==4'b1111, ci SHALL increment mod 4 and the divider restarts.
REQ-015 SCAN sample with any rs bit low: latch row_idx = lowest low bit index, keep ci frozen, clear the debounce counter, go to DEBOUNCE.
REQ-016 DEBOUNCE: each cycle the latched row bit SHALL be low and all lower-index bits high, else return to SCAN with no output, divider restarted, ci unchanged.
REQ-017 DEBOUNCE stable for DEBOUNCE_CYC consecutive cycles: go to HELD, register key_code={row_idx,ci}, pulse key_valid for exactly one cycle, coincident with key_code update.
REQ-018 HELD: ci frozen; when rs==4'b1111, clear the debounce counter and go to RELEASE.
REQ-019 RELEASE: any rs bit low returns to HELD without a new key_valid; rs==4'b1111 for DEBOUNCE_CYC consecutive cycles -> SCAN, ci increments mod 4, divider restarts.
REQ-020 key_down SHALL equal (state==HELD or state==RELEASE), registered.
REQ-021 Multiple simultaneous keys in one column: lowest row index wins; keys in other columns are ignored until return to SCAN.
REQ-022 key_code SHALL hold its value until the next accepted key.

Reset
REQ-023 On reset assertion, immediately: state=SCAN, ci=0, col=4'b1110, divider=0, debounce counter=0, synchronizer=4'b1111, key_code=0, key_valid=0, key_down=0, entry_data=0.
REQ-024 Reset mid-DEBOUNCE or mid-HELD SHALL discard the key; no key_valid is produced after release of reset until a full new debounce completes.

Configuration
REQ-025 Macro KEYPAD_SCAN_ENTRY_SHIFT_EN defined: on each key_valid cycle edge, entry_data <= {entry_data[11:0], key_code_new}, updating on the same edge as key_valid rises.
REQ-026 Macro undefined: entry_data SHALL be constant 16'h0000 and no shift register is synthesized.

Structure
REQ-027 Package keypad_pkg SHALL hold the state enum typedef, the SCAN_DIV/DEBOUNCE_CYC defaults, and the idle-row constant 4'b1111.
REQ-028 One sub-module, keypad_sync (parameterised-width 2-flop synchronizer, reset to all-ones), SHALL be instantiated for row.

Verification (SCAN_DIV=8, DEBOUNCE_CYC=16)
REQ-029 Reset released, no key -> col cycles 1110,1101,1011,0111 at 8-cycle intervals, key_valid never high.
REQ-030 row=4'b1011 held while col=4'b1101 -> after 16 stable cycles one key_valid pulse, key_code=4'h9, key_down=1, col frozen at 1101.
REQ-031 Press as REQ-030 bouncing (row toggles high after 5 cycles) -> FSM returns to SCAN, no key_valid.
REQ-032 Release glitch (row high 6 cycles, then low again) -> stays HELD, no second key_valid; clean release 16 cycles -> key_down=0, col advances to 1011.
REQ-033 With KEYPAD_SCAN_ENTRY_SHIFT_EN, press keys 1,2,3,4 sequentially -> entry_data=16'h1234; fifth key 0xA -> 16'h234A.
REQ-034 reset asserted during HELD -> all outputs at reset values that cycle; rows still low after release -> new full debounce before key_valid.
